// File: rtl/hazard_unit_pkg.sv
// Shared constants, slot record and match helpers for the RAW-hazard resolver.
package hazard_unit_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    // x0 is hardwired zero, so it never produces a hazard.
    function automatic logic slot_match(slot_t s, logic [REG_W-1:0] rs);
        return s.valid & s.reg_write & (s.rd == rs) & (rs != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, logic [REG_W-1:0] rs);
        if (slot_match(ex, rs) && !ex.mem_read) begin
            return FWD_MEM;
        end else if (slot_match(mem, rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage request and hazard/forwarding response bundle.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 16
);
    import hazard_unit_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic             id_byp_a;
    logic             id_byp_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
        input  stall, ex_fwd_a, ex_fwd_b, id_byp_a, id_byp_b, stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
        output stall, ex_fwd_a, ex_fwd_b, id_byp_a, id_byp_b, stall_cnt, fwd_cnt
    );

endinterface

// File: rtl/hazard_slot.sv
// One shadow-pipeline register holding a destination tag; loads zeros on bubble.
module hazard_slot
    import hazard_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  bubble_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    slot_t slot_d, slot_q;

    always_comb begin
        slot_d = bubble_i ? '0 : slot_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/hazard_unit.sv
// RAW-hazard resolver: EX/MEM/WB tag shadow pipeline, registered forward selects,
// ID regfile bypass flags, one-cycle load-use stall and saturating event counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_unit_if.slave hif
);

    slot_t      id_slot, ex_slot, mem_slot, wb_slot;
    logic       load_use, stall, id_bubble, fwd_hit;
    logic [1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, fwd_cnt_d, fwd_cnt_q;
    logic       unused_slot_bits;

    always_comb begin
        id_slot           = '0;
        id_slot.valid     = hif.id_valid;
        id_slot.rd        = hif.id_rd;
        id_slot.reg_write = hif.id_reg_write;
        id_slot.mem_read  = hif.id_mem_read;

        load_use = hif.id_valid & ex_slot.mem_read &
                   (slot_match(ex_slot, hif.id_rs1) | slot_match(ex_slot, hif.id_rs2));
        // A redirect kills the ID instruction, so it cannot also be held.
        stall     = load_use & ~hif.flush;
        id_bubble = ~hif.id_valid | stall | hif.flush;

        fwd_a_d = id_bubble ? FWD_REG : fwd_sel(ex_slot, mem_slot, hif.id_rs1);
        fwd_b_d = id_bubble ? FWD_REG : fwd_sel(ex_slot, mem_slot, hif.id_rs2);
        fwd_hit = ~id_bubble & ((fwd_a_d != FWD_REG) | (fwd_b_d != FWD_REG));

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        fwd_cnt_d = fwd_cnt_q;
        if (fwd_hit && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    hazard_slot u_ex_slot (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (id_bubble),
        .slot_i   (id_slot),
        .slot_o   (ex_slot)
    );

    hazard_slot u_mem_slot (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .slot_i   (ex_slot),
        .slot_o   (mem_slot)
    );

    hazard_slot u_wb_slot (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .slot_i   (mem_slot),
        .slot_o   (wb_slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q     <= FWD_REG;
            fwd_b_q     <= FWD_REG;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign hif.stall     = stall;
    assign hif.ex_fwd_a  = fwd_a_q;
    assign hif.ex_fwd_b  = fwd_b_q;
    assign hif.id_byp_a  = hif.id_valid & slot_match(wb_slot, hif.id_rs1);
    assign hif.id_byp_b  = hif.id_valid & slot_match(wb_slot, hif.id_rs2);
    assign hif.stall_cnt = stall_cnt_q;
    assign hif.fwd_cnt   = fwd_cnt_q;

    // Load flag only matters while the producer sits in EX.
    assign unused_slot_bits = ^{mem_slot.mem_read, wb_slot.mem_read};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction-history model plus literal checkpoints,
// run on a 16-bit-counter instance and a 2-bit-counter instance in parallel.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_reg_write, id_mem_read, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;

    hazard_unit_if #(.CNT_W(16)) hif ();
    hazard_unit_if #(.CNT_W(2))  sif ();

    assign hif.id_valid     = id_valid;
    assign hif.id_rs1       = id_rs1;
    assign hif.id_rs2       = id_rs2;
    assign hif.id_rd        = id_rd;
    assign hif.id_reg_write = id_reg_write;
    assign hif.id_mem_read  = id_mem_read;
    assign hif.flush        = flush;
    assign sif.id_valid     = id_valid;
    assign sif.id_rs1       = id_rs1;
    assign sif.id_rs2       = id_rs2;
    assign sif.id_rd        = id_rd;
    assign sif.id_reg_write = id_reg_write;
    assign sif.id_mem_read  = id_mem_read;
    assign sif.flush        = flush;

    hazard_unit #(.CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    hazard_unit #(.CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .hif (sif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the last three instructions issued to EX, nearest first.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    ins_t inflight [3];
    int   m_fwd_a, m_fwd_b, m_stall_cnt, m_fwd_cnt;

    function automatic bit writes(ins_t p, int rs);
        return p.v && p.rw && (rs != 0) && (p.rd == rs);
    endfunction

    function automatic bit m_stall();
        return id_valid && !flush && inflight[0].mr &&
               (writes(inflight[0], int'(id_rs1)) || writes(inflight[0], int'(id_rs2)));
    endfunction

    function automatic int m_sel(int rs);
        if (writes(inflight[0], rs) && !inflight[0].mr) return 1;
        if (writes(inflight[1], rs)) return 2;
        return 0;
    endfunction

    function automatic int sat(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) inflight[i] = '{0, 0, 0, 0};
            m_fwd_a     = 0;
            m_fwd_b     = 0;
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
        end else begin
            bit   enter;
            ins_t nw;
            enter = id_valid && !flush && !m_stall();
            if (m_stall()) m_stall_cnt++;
            nw = enter ? '{1, int'(id_rd), id_reg_write, id_mem_read} : '{0, 0, 0, 0};
            m_fwd_a = enter ? m_sel(int'(id_rs1)) : 0;
            m_fwd_b = enter ? m_sel(int'(id_rs2)) : 0;
            if (enter && (m_fwd_a != 0 || m_fwd_b != 0)) m_fwd_cnt++;
            inflight[2] = inflight[1];
            inflight[1] = inflight[0];
            inflight[0] = nw;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("stall", int'(hif.stall), int'(m_stall()));
            check("byp_a", int'(hif.id_byp_a), int'(id_valid && writes(inflight[2], int'(id_rs1))));
            check("byp_b", int'(hif.id_byp_b), int'(id_valid && writes(inflight[2], int'(id_rs2))));
            check("fwd_a", int'(hif.ex_fwd_a), m_fwd_a);
            check("fwd_b", int'(hif.ex_fwd_b), m_fwd_b);
            check("stall_cnt", int'(hif.stall_cnt), sat(m_stall_cnt, 65535));
            check("fwd_cnt", int'(hif.fwd_cnt), sat(m_fwd_cnt, 65535));
            check("sat_stall_cnt", int'(sif.stall_cnt), sat(m_stall_cnt, 3));
            check("sat_fwd_cnt", int'(sif.fwd_cnt), sat(m_fwd_cnt, 3));
        end
    end

    // Drives one ID-stage cycle just after the edge; returns 2 time units in.
    task automatic cyc(input bit v, input int s1, input int s2, input int d,
                       input bit w, input bit m, input bit f);
        int t1, t2, td;
        @(posedge clk);
        #1;
        t1 = s1; t2 = s2; td = d;
        id_valid     = v;
        id_rs1       = t1[4:0];
        id_rs2       = t2[4:0];
        id_rd        = td[4:0];
        id_reg_write = w;
        id_mem_read  = m;
        flush        = f;
        #1;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fwd_a", int'(hif.ex_fwd_a), 0);
        check("rst_stall", int'(hif.stall), 0);
        check("rst_stall_cnt", int'(hif.stall_cnt), 0);
        rst = 1'b0;
        nop();

        // sub x1,x3,x2 ; add x4,x1,x3 ; add x5,x2,x1 ; add x10,x1,x1
        cyc(1, 3, 2, 1, 1, 0, 0);
        cyc(1, 1, 3, 4, 1, 0, 0);
        check("chain_no_stall", int'(hif.stall), 0);
        cyc(1, 2, 1, 5, 1, 0, 0);
        check("chain_fwd_a_mem", int'(hif.ex_fwd_a), 1);
        check("chain_fwd_b_reg", int'(hif.ex_fwd_b), 0);
        cyc(1, 1, 1, 10, 1, 0, 0);
        check("d3_byp_a", int'(hif.id_byp_a), 1);
        check("d3_byp_b", int'(hif.id_byp_b), 1);
        check("d2_fwd_b_wb", int'(hif.ex_fwd_b), 2);
        nop();
        check("d3_fwd_a_reg", int'(hif.ex_fwd_a), 0);
        check("d3_fwd_b_reg", int'(hif.ex_fwd_b), 0);
        repeat (3) nop();
        check("chain_fwd_cnt", int'(hif.fwd_cnt), 2);

        // lw x6,0(x0) ; add x7,x6,x6
        cyc(1, 0, 0, 6, 1, 1, 0);
        cyc(1, 6, 6, 7, 1, 0, 0);
        check("lu_stall", int'(hif.stall), 1);
        cyc(1, 6, 6, 7, 1, 0, 0);
        check("lu_stall_once", int'(hif.stall), 0);
        check("lu_bubble_fwd", int'(hif.ex_fwd_a), 0);
        nop();
        check("lu_fwd_a_wb", int'(hif.ex_fwd_a), 2);
        check("lu_fwd_b_wb", int'(hif.ex_fwd_b), 2);
        check("lu_stall_cnt", int'(hif.stall_cnt), 1);
        repeat (3) nop();

        // add x0,x1,x1 ; add x8,x0,x0
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 8, 1, 0, 0);
        check("x0_no_stall", int'(hif.stall), 0);
        nop();
        check("x0_fwd_a", int'(hif.ex_fwd_a), 0);
        check("x0_fwd_b", int'(hif.ex_fwd_b), 0);
        repeat (2) nop();

        // Flush coinciding with a load-use hazard
        cyc(1, 0, 0, 6, 1, 1, 0);
        cyc(1, 6, 6, 7, 1, 0, 1);
        check("flush_no_stall", int'(hif.stall), 0);
        nop();
        check("flush_bubble", int'(hif.ex_fwd_a), 0);
        check("flush_stall_cnt", int'(hif.stall_cnt), 1);
        repeat (2) nop();

        // Reset asserted in the middle of a stall cycle
        cyc(1, 0, 0, 6, 1, 1, 0);
        cyc(1, 6, 6, 7, 1, 0, 0);
        check("pre_rst_stall", int'(hif.stall), 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_stall", int'(hif.stall), 0);
        check("mid_rst_stall_cnt", int'(hif.stall_cnt), 0);
        check("mid_rst_fwd_cnt", int'(hif.fwd_cnt), 0);
        check("mid_rst_sat_cnt", int'(sif.stall_cnt), 0);
        rst = 1'b0;
        repeat (2) nop();

        // Five load-use stalls: 16-bit counter reaches 5, 2-bit counter pins at 3
        repeat (5) begin
            cyc(1, 0, 0, 6, 1, 1, 0);
            cyc(1, 6, 6, 7, 1, 0, 0);
            cyc(1, 6, 6, 7, 1, 0, 0);
        end
        nop();
        check("sat_main_stall_cnt", int'(hif.stall_cnt), 5);
        check("sat_small_stall_cnt", int'(sif.stall_cnt), 3);
        check("sat_main_fwd_cnt", int'(hif.fwd_cnt), 5);
        check("sat_small_fwd_cnt", int'(sif.fwd_cnt), 3);
        repeat (3) nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Sequential RAW-hazard resolver for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Tracks destination-register tags of in-flight instructions in an internal EX/MEM/WB shadow pipeline.
- Produces registered EX-stage forwarding selects, ID-stage regfile bypass flags, and a one-cycle load-use stall.
- Sits beside the control unit; the datapath consumes the selects on its ALU operand muxes.

Parameters:
- CNT_W, 16, width of the stall and forward event counters (saturating).

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_rd  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch/jump redirect; kill the ID instruction
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- ex_fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM ALU result, 10 WB data
- ex_fwd_b  out  2  same encoding for operand B
- id_byp_a  out  1  ID rs1 read must take WB write data (regfile write-after-read)
- id_byp_b  out  1  same for rs2
- stall_cnt  out  CNT_W  cycles stalled since reset
- fwd_cnt  out  CNT_W  instructions entering EX with any nonzero select

Behaviour:
- Shadow pipeline: three slots (EX, MEM, WB). Each slot holds valid, rd, reg_write and mem_read. All slots shift on every clock edge; there is no global freeze.
- ID→EX slot input: the ID fields when id_valid=1, stall=0 and flush=0; otherwise a bubble (all fields 0).
- Match(slot, rs): slot.valid & slot.reg_write & (slot.rd == rs) & (rs != 0). x0 never matches.
- Load-use stall (combinational): id_valid & Match(EX, rs1 or rs2) & EX.mem_read.
  - Exactly one cycle: the load moves to MEM and the bubble enters EX.
  - The next-cycle forward then selects 10.
- Forward selects are computed at ID and registered into ex_fwd_a/b on the edge the instruction enters EX:
  - Match(EX) & !EX.mem_read -> 01.
  - else Match(MEM) -> 10.
  - else 00.
  - Nearest producer wins.
  - Bubble entering EX -> both selects 00.
- ID bypass (combinational): id_byp_a = Match(WB, id_rs1); id_byp_b = Match(WB, id_rs2). Covers the producer writing at the same edge ID reads.
- Simultaneous events:
  - flush & stall -> flush wins: stall=0, a bubble enters EX, stall_cnt does not increment.
  - id_valid=0 -> stall=0 and bypass flags 0.
- Counters:
  - stall_cnt increments on every edge where stall=1.
  - fwd_cnt increments when a non-bubble enters EX with a nonzero select.
  - Both saturate at all-ones; no wrap.
- Reset (async, any time, including mid-stall): all slots invalid, ex_fwd_a/b=00, counters 0. stall and id_byp_a/b evaluate to 0 while the slots are empty.
- Latency:
  - stall and bypass flags: 0 cycles (combinational from registered slots and ID inputs).
  - forward selects: 1 cycle (valid during the instruction's EX cycle).

Decomposition:
- Shared package/include holds:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10 constants.
  - Slot field widths (REG_W=5).
- One natural sub-module: hazard_slot. It is a single valid/rd/reg_write/mem_read pipeline register with async reset and bubble insert, instantiated three times.

Test Plan:
- Back-to-back ALU chain (sub x1,x3,x2; add x4,x1,x3) -> second instruction sees ex_fwd_a=01 in EX, stall never 1; integrated CPU yields x1=1, x4=4.
- Distance-2 and distance-3 use (add x5,x2,x1 then add x10,x1,x1, preceded by that chain):
  - add x5 -> ex_fwd_b=10.
  - add x10 -> id_byp_a=id_byp_b=1 in ID, selects 00.
  - Result: x5=3, x10=2.
  - fwd_cnt=2 after drain; bypass does not count.
- Load-use (lw x6,0(x0); add x7,x6,x6) -> stall=1 for exactly one cycle, bubble in EX, then ex_fwd_a=ex_fwd_b=10; stall_cnt=1.
- x0 destination (add x0,x1,x1; add x8,x0,x0) -> no stall, selects 00, bypass 0.
- Flush during a load-use condition -> stall=0, bubble enters EX, stall_cnt unchanged. rst asserted mid-stall -> slots cleared immediately, stall=0, counters 0.
- Counter saturation with CNT_W=2 -> after 5 stall cycles stall_cnt=3, holds.
